blif_line_reader: RTL and testbench
===================================

Name: blif_line_reader

Overview:
- Streaming reader for BLIF netlist text, the reading end of the BLIF writer backend's output.
- Consumes ASCII bytes over a valid/ready handshake, splits them into lines and whitespace-delimited tokens, classifies each line's directive, and emits one record per non-empty line.
- Used as a hardware-side checker in backend round-trip test benches.

Parameters:
- CNT_W, 8, width of the token counter and out_tokens; saturating.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data holds a byte
- in_ready  output  1  reader accepts a byte this cycle
- in_data  input  8  ASCII byte
- out_valid  output  1  line record available
- out_ready  input  1  downstream accepts the record
- out_kind  output  3  line classification: 0 reserved, 1 .model, 2 .inputs, 3 .outputs, 4 .names, 5 .latch, 6 .end, 7 other
- out_tokens  output  CNT_W  number of tokens on the line, including the directive
- out_overflow  output  1  token count saturated
- err  output  1  one-cycle pulse when an illegal byte is accepted

Behaviour:
- Clock and reset:
  - Single clock clk; rst is synchronous and active-high.
  - While rst is high and on the first cycle after: in_ready=0, out_valid=0, out_kind=0, out_tokens=0, out_overflow=0, err=0, state=WS, counters cleared.
  - in_ready=1 from the second cycle after rst deasserts.
  - rst mid-line discards the partial line; rst while out_valid is high drops the record.
- A byte is accepted when in_valid & in_ready.
- Byte classes:
  - Space 0x20 and tab 0x09 are separators.
  - LF 0x0A is end of line.
  - CR 0x0D is ignored entirely.
  - '#' 0x23 starts a comment.
  - 0x21..0x7E other than '#' are token characters.
  - Any other value is illegal: err=1 for the cycle after acceptance, byte otherwise ignored, state unchanged.
- States:
  - WS:
    - Token char -> TOK; the token count increments (saturating), and this is the start of the first token when count was 0.
    - Separator -> WS.
    - '#' -> CMT.
    - LF -> EMIT if count>0, else stay WS (blank line: no record).
  - TOK:
    - Token char -> TOK.
    - Separator -> WS.
    - '#' -> CMT; ends the token.
    - LF -> EMIT.
  - CMT:
    - All bytes except LF are discarded.
    - LF -> EMIT if count>0, else WS.
  - EMIT:
    - out_valid=1 starting the cycle after the LF is accepted; in_ready=0.
    - out_kind, out_tokens and out_overflow are held stable until out_valid & out_ready.
    - On acceptance: out_valid=0 next cycle, in_ready=1 next cycle, state -> WS, count and match cleared.
- Directive match:
  - The first token of each line is compared character by character against .model, .inputs, .outputs, .names, .latch and .end, using one match flag per keyword.
  - A flag clears on a mismatching character or when the token runs longer than its keyword.
  - When the first token ends, exactly one surviving full-length flag selects kind 1..6; otherwise kind=7.
  - Matching is case-sensitive. ".endx" gives kind 7.
- Counting:
  - The token count saturates at 2^CNT_W-1.
  - out_overflow=1 when a token start is seen with the count already at max.
- Throughput:
  - One byte per cycle while not in EMIT.
  - Minimum line cost is byte count plus 1 cycle, plus any out_ready stall.
- Simultaneous events: rst dominates both handshakes; in_valid is ignored while in EMIT.

Test Plan:
1. ".names a b y\n", out_ready=1 -> one record kind=4 tokens=4 overflow=0; out_valid rises 1 cycle after LF accepted and lasts 1 cycle.
2. "  # comment\n\n\t\n" -> no record; in_ready stays 1 throughout; err never pulses.
3. ".end\n" with out_ready=0 for 5 cycles -> out_valid=1, in_ready=0, kind=6 tokens=1 stable all 5 cycles; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
4. "11 1\n" -> kind=7 tokens=2. ".endx y\n" -> kind=7 tokens=2. ".latch d q re clk 0\r\n" -> kind=5 tokens=6.
5. CNT_W=2, "a b c d e\n" -> tokens=3 overflow=1.
6. Byte 0x01 inside ".inp", then "uts x\n" -> err pulses once, record kind=2 tokens=2. Separately, "a b" then rst, then ".end\n" -> single record kind=6 tokens=1.

Source files
------------

// File: rtl/blif_line_reader_if.sv
// Byte-in / line-record-out interface of the BLIF line reader.
// The reader sits on the slave side; the byte source and record sink sit on the master side.
interface blif_line_reader_if #(
  parameter int unsigned CNT_W = 8
);
  // Byte stream
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  // Line record
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_kind;
  logic [CNT_W-1:0] out_tokens;
  logic             out_overflow;
  // Illegal-byte pulse
  logic             err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_kind, out_tokens, out_overflow, err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_kind, out_tokens, out_overflow, err
  );
endinterface

// File: rtl/blif_line_reader.sv
// Streaming BLIF line reader: splits an ASCII byte stream into lines and whitespace-delimited
// tokens, classifies the directive in the first token and emits one record per non-empty line.
module blif_line_reader #(
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  blif_line_reader_if.slave bus
);

  localparam int unsigned    NumKw  = 6;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StWs, StTok, StCmt, StEmit} state_e;

  // Keyword k (0 .model, 1 .inputs, 2 .outputs, 3 .names, 4 .latch, 5 .end), character p.
  // Positions past the keyword return 0, which never equals a token character.
  function automatic logic [7:0] kw_char(input int unsigned k, input logic [3:0] p);
    logic [63:0] s;
    case (k)
      0:       s = {".model", 16'h0};
      1:       s = {".inputs", 8'h0};
      2:       s = ".outputs";
      3:       s = {".names", 16'h0};
      4:       s = {".latch", 16'h0};
      5:       s = {".end", 32'h0};
      default: s = '0;
    endcase
    if (p > 4'd7) return 8'h00;
    return s[8*(7-int'(p)) +: 8];
  endfunction

  function automatic logic [3:0] kw_len(input int unsigned k);
    case (k)
      0:       return 4'd6;
      1:       return 4'd7;
      2:       return 4'd8;
      3:       return 4'd6;
      4:       return 4'd6;
      5:       return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // Advance every match flag by one character at position p of the first token.
  function automatic logic [NumKw-1:0] match_step(input logic [NumKw-1:0] m,
                                                  input logic [3:0]       p,
                                                  input logic [7:0]       c);
    logic [NumKw-1:0] r;
    for (int unsigned k = 0; k < NumKw; k++) begin
      r[k] = m[k] && (p < kw_len(k)) && (c == kw_char(k, p));
    end
    return r;
  endfunction

  // A flag only counts once the token reached exactly its keyword's length.
  function automatic logic [2:0] kind_decode(input logic [NumKw-1:0] m, input logic [3:0] p);
    logic [NumKw-1:0] hit;
    logic [2:0]       kind;
    for (int unsigned k = 0; k < NumKw; k++) begin
      hit[k] = m[k] && (p == kw_len(k));
    end
    kind = 3'd7;
    if ($countones(hit) == 1) begin
      for (int unsigned k = 0; k < NumKw; k++) begin
        if (hit[k]) kind = 3'(k + 1);
      end
    end
    return kind;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       kind_q, kind_d;
  logic [NumKw-1:0] match_q, match_d;
  logic [3:0]       pos_q, pos_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             started_q;

  logic is_sep, is_lf, is_cr, is_hash, is_tok, is_ill;
  logic in_ready_w, accept;
  logic tok_start, tok_end;

  // Byte classification and handshake qualification
  always_comb begin
    is_sep     = (bus.in_data == 8'h20) || (bus.in_data == 8'h09);
    is_lf      = (bus.in_data == 8'h0a);
    is_cr      = (bus.in_data == 8'h0d);
    is_hash    = (bus.in_data == 8'h23);
    is_tok     = (bus.in_data >= 8'h21) && (bus.in_data <= 8'h7e) && !is_hash;
    is_ill     = !(is_sep || is_lf || is_cr || is_hash || is_tok);
    // started_q keeps in_ready low for the first cycle after reset
    in_ready_w = started_q && (state_q != StEmit) && !rst;
    accept     = bus.in_valid && in_ready_w;
  end

  // Next-state logic: tokenizer FSM, token counter and directive matcher
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    kind_d    = kind_q;
    match_d   = match_q;
    pos_d     = pos_q;
    first_d   = first_q;
    err_d     = 1'b0;
    tok_start = 1'b0;
    tok_end   = 1'b0;

    if (accept) begin
      err_d = is_ill;
      // Illegal bytes and CR fall through every branch and leave the state untouched.
      unique case (state_q)
        StWs: begin
          if (is_tok) begin
            state_d   = StTok;
            tok_start = 1'b1;
          end else if (is_hash) begin
            state_d = StCmt;
          end else if (is_lf && (cnt_q != '0)) begin
            state_d = StEmit;
          end
        end
        StTok: begin
          if (is_sep) begin
            state_d = StWs;
            tok_end = 1'b1;
          end else if (is_hash) begin
            state_d = StCmt;
            tok_end = 1'b1;
          end else if (is_lf) begin
            state_d = StEmit;
            tok_end = 1'b1;
          end else if (is_tok && first_q) begin
            match_d = match_step(match_q, pos_q, bus.in_data);
            pos_d   = (pos_q == 4'hf) ? pos_q : pos_q + 4'd1;
          end
        end
        StCmt: begin
          if (is_lf) state_d = (cnt_q != '0) ? StEmit : StWs;
        end
        StEmit: ;
      endcase
    end

    if (tok_start) begin
      if (cnt_q == CntMax) ovf_d = 1'b1;
      else                 cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == '0) begin
        first_d = 1'b1;
        match_d = match_step('1, 4'd0, bus.in_data);
        pos_d   = 4'd1;
      end
    end

    if (tok_end && first_q) begin
      kind_d  = kind_decode(match_q, pos_q);
      first_d = 1'b0;
    end

    // Record taken: start a fresh line
    if ((state_q == StEmit) && bus.out_ready) begin
      state_d = StWs;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      kind_d  = 3'd0;
      match_d = '0;
      pos_d   = 4'd0;
      first_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StWs;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      kind_q    <= 3'd0;
      match_q   <= '0;
      pos_q     <= 4'd0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      kind_q    <= kind_d;
      match_q   <= match_d;
      pos_q     <= pos_d;
      first_q   <= first_d;
      err_q     <= err_d;
      started_q <= 1'b1;
    end
  end

  // Outputs; the line registers are frozen in StEmit, so the record is stable until taken.
  // rst forces every output low, including the cycle it is first asserted.
  always_comb begin
    bus.in_ready     = in_ready_w;
    bus.out_valid    = (state_q == StEmit) && !rst;
    bus.out_kind     = rst ? 3'd0 : kind_q;
    bus.out_tokens   = rst ? '0 : cnt_q;
    bus.out_overflow = ovf_q && !rst;
    bus.err          = err_q && !rst;
  end

endmodule

// File: tb/tb_blif_line_reader.sv
// Bench for blif_line_reader: two instances (CNT_W=8 and CNT_W=2) see the same byte stream;
// directed lines plus random lines checked against a string-level line model.
module tb_blif_line_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;

  always #5 clk = ~clk;

  blif_line_reader_if #(.CNT_W(8)) if8 ();
  blif_line_reader_if #(.CNT_W(2)) if2 ();

  assign if8.in_valid  = in_valid;
  assign if8.in_data   = in_data;
  assign if8.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_data   = in_data;
  assign if2.out_ready = out_ready;

  blif_line_reader #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  blif_line_reader #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int n_cmp = 0;
  int n_mis = 0;
  int errs8 = 0;
  int errs2 = 0;
  int line_no = 0;

  logic [7:0] lq[$];
  string kws[6] = '{".model", ".inputs", ".outputs", ".names", ".latch", ".end"};

  // Count err pulses, one per cycle
  always @(negedge clk) begin
    if (if8.err === 1'b1) errs8++;
    if (if2.err === 1'b1) errs2++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h09) || (b == 8'h0a) || (b == 8'h0d) ||
           ((b >= 8'h21) && (b <= 8'h7e));
  endfunction

  function automatic void clear_lq();
    lq = {};
  endfunction

  function automatic void add_str(input string s);
    for (int i = 0; i < s.len(); i++) lq.push_back(s[i]);
  endfunction

  // Line model: drop illegal bytes and CR, cut at '#', split on blanks, name the first token.
  function automatic void ref_line(output bit has, output int kind, output int ntok,
                                   output int nill);
    string toks[$];
    string cur;
    bit    cmt;
    cur  = "";
    cmt  = 1'b0;
    nill = 0;
    foreach (lq[i]) begin
      if (!legal(lq[i])) nill++;
      else if (cmt || (lq[i] == 8'h0d)) begin end
      else if (lq[i] == 8'h23) begin
        if (cur != "") toks.push_back(cur);
        cur = "";
        cmt = 1'b1;
      end else if ((lq[i] == 8'h20) || (lq[i] == 8'h09)) begin
        if (cur != "") toks.push_back(cur);
        cur = "";
      end else begin
        cur = $sformatf("%s%c", cur, lq[i]);
      end
    end
    if (cur != "") toks.push_back(cur);
    ntok = toks.size();
    has  = (ntok > 0);
    kind = 0;
    if (has) begin
      kind = 7;
      for (int k = 0; k < 6; k++) if (toks[0] == kws[k]) kind = k + 1;
    end
  endfunction

  function automatic logic [7:0] rand_illegal();
    logic [7:0] t[8] = '{8'h00, 8'h01, 8'h07, 8'h0b, 8'h1f, 8'h7f, 8'h80, 8'hff};
    return t[$urandom_range(0, 7)];
  endfunction

  function automatic void add_noise();
    int r = $urandom_range(0, 24);
    if (r == 0) lq.push_back(rand_illegal());
    else if (r == 1) lq.push_back(8'h0d);
  endfunction

  function automatic void add_seps();
    int n = $urandom_range(1, 2);
    for (int i = 0; i < n; i++) lq.push_back($urandom_range(0, 1) ? 8'h20 : 8'h09);
  endfunction

  function automatic void gen_line();
    int         n;
    int         k;
    int         m;
    int         len;
    logic [7:0] c;
    string      s;
    clear_lq();
    n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 7);
    if ($urandom_range(0, 1)) add_seps();
    for (int t = 0; t < n; t++) begin
      if (t > 0) add_seps();
      if ($urandom_range(0, 2) != 0 && t == 0 || $urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, 5);
        m = $urandom_range(0, 3);
        s = kws[k];
        len = (m == 2) ? s.len() - 1 : s.len();
        for (int i = 0; i < len; i++) begin
          c = s[i];
          if ((m == 3) && (i == 1)) c = c ^ 8'h20;
          lq.push_back(c);
          add_noise();
        end
        if (m == 1) lq.push_back("x");
      end else begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
          c = 8'($urandom_range(33, 126));
          if (c == 8'h23) c = 8'h24;
          lq.push_back(c);
          add_noise();
        end
      end
    end
    if ($urandom_range(0, 1)) add_seps();
    if ($urandom_range(0, 3) == 0) begin
      lq.push_back(8'h23);
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h0a) c = 8'h41;
        lq.push_back(c);
      end
    end
    if ($urandom_range(0, 4) == 0) lq.push_back(8'h0d);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int w;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!(if8.in_ready && if2.in_ready) && (w < 20)) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check_eq($sformatf("L%0d in_ready timeout", line_no), 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_rec(input string ph, input int kind, input int t8, input int o8,
                           input int t2, input int o2);
    check_eq($sformatf("L%0d %s out_valid8", line_no, ph), if8.out_valid, 1);
    check_eq($sformatf("L%0d %s out_valid2", line_no, ph), if2.out_valid, 1);
    check_eq($sformatf("L%0d %s in_ready8", line_no, ph), if8.in_ready, 0);
    check_eq($sformatf("L%0d %s kind8", line_no, ph), if8.out_kind, kind);
    check_eq($sformatf("L%0d %s kind2", line_no, ph), if2.out_kind, kind);
    check_eq($sformatf("L%0d %s tokens8", line_no, ph), if8.out_tokens, t8);
    check_eq($sformatf("L%0d %s overflow8", line_no, ph), if8.out_overflow, o8);
    check_eq($sformatf("L%0d %s tokens2", line_no, ph), if2.out_tokens, t2);
    check_eq($sformatf("L%0d %s overflow2", line_no, ph), if2.out_overflow, o2);
  endtask

  // Sends lq plus LF, then checks the record (or its absence) and the err pulse count.
  task automatic send_line(input int stall, input bit gaps, input bit has, input int kind,
                           input int ntok, input int nill);
    int b8;
    int b2;
    int t8;
    int o8;
    int t2;
    int o2;
    line_no++;
    b8 = errs8;
    b2 = errs2;
    t8 = (ntok > 255) ? 255 : ntok;
    o8 = (ntok > 255) ? 1 : 0;
    t2 = (ntok > 3) ? 3 : ntok;
    o2 = (ntok > 3) ? 1 : 0;
    out_ready = (stall == 0);
    foreach (lq[i]) send_byte(lq[i], gaps);
    send_byte(8'h0a, gaps);
    if (has) begin
      check_rec("first", kind, t8, o8, t2, o2);
      // A byte offered during the record must be ignored
      if (stall > 0) begin
        in_valid = 1'b1;
        in_data  = "Z";
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check_rec("held", kind, t8, o8, t2, o2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq($sformatf("L%0d out_valid after take", line_no), if8.out_valid, 0);
      check_eq($sformatf("L%0d in_ready after take", line_no), if8.in_ready, 1);
    end else begin
      check_eq($sformatf("L%0d no record", line_no), if8.out_valid, 0);
      check_eq($sformatf("L%0d in_ready kept", line_no), if8.in_ready, 1);
    end
    check_eq($sformatf("L%0d err pulses8", line_no), errs8 - b8, nill);
    check_eq($sformatf("L%0d err pulses2", line_no), errs2 - b2, nill);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst in_ready", if8.in_ready, 0);
    check_eq("rst out_valid8", if8.out_valid, 0);
    check_eq("rst out_valid2", if2.out_valid, 0);
    check_eq("rst out_kind", if8.out_kind, 0);
    check_eq("rst out_tokens", if8.out_tokens, 0);
    check_eq("rst out_overflow", if8.out_overflow, 0);
    check_eq("rst err", if8.err, 0);
    rst = 1'b0;
    #1;
    check_eq("first cycle after rst in_ready", if8.in_ready, 0);
    @(negedge clk);
    check_eq("second cycle after rst in_ready8", if8.in_ready, 1);
    check_eq("second cycle after rst in_ready2", if2.in_ready, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit has;
    int kind;
    int ntok;
    int nill;

    do_reset();

    clear_lq(); add_str(".names a b y");
    send_line(0, 1'b0, 1'b1, 4, 4, 0);

    clear_lq(); add_str("  # comment");
    send_line(0, 1'b0, 1'b0, 0, 0, 0);
    clear_lq();
    send_line(0, 1'b0, 1'b0, 0, 0, 0);
    clear_lq(); lq.push_back(8'h09);
    send_line(0, 1'b0, 1'b0, 0, 0, 0);

    clear_lq(); add_str(".end");
    send_line(5, 1'b0, 1'b1, 6, 1, 0);

    clear_lq(); add_str("11 1");
    send_line(0, 1'b0, 1'b1, 7, 2, 0);
    clear_lq(); add_str(".endx y");
    send_line(1, 1'b0, 1'b1, 7, 2, 0);
    clear_lq(); add_str(".latch d q re clk 0"); lq.push_back(8'h0d);
    send_line(0, 1'b0, 1'b1, 5, 6, 0);

    clear_lq(); add_str("a b c d e");
    send_line(0, 1'b0, 1'b1, 7, 5, 0);

    clear_lq(); add_str(".inp"); lq.push_back(8'h01); add_str("uts x");
    send_line(0, 1'b0, 1'b1, 2, 2, 1);

    // Partial line lost to reset
    clear_lq(); add_str("a b");
    foreach (lq[i]) send_byte(lq[i], 1'b0);
    do_reset();
    clear_lq(); add_str(".end");
    send_line(0, 1'b0, 1'b1, 6, 1, 0);

    // Saturate the 8-bit counter too
    clear_lq();
    for (int i = 0; i < 260; i++) add_str("a ");
    send_line(2, 1'b0, 1'b1, 7, 260, 0);

    for (int n = 0; n < 200; n++) begin
      gen_line();
      ref_line(has, kind, ntok, nill);
      send_line($urandom_range(0, 3), 1'b1, has, kind, ntok, nill);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
